// File: rtl/fir_coeff_pkg.sv
// Shared constants, state encoding and RAM strobe levels for the FIR coefficient path.
package fir_coeff_pkg;
  localparam int COEFF_W    = 16;
  localparam int BANK_DEPTH = 10;
  localparam int NUM_BANK   = 4;
  localparam int MAX_TAPS   = NUM_BANK * BANK_DEPTH;
  localparam int ADDR_W     = 4;
  localparam int TAP_W      = 6;

  typedef enum logic [2:0] {IDLE, ARM, STREAM, FILL, DONE} state_t;

  localparam logic CSN_IDLE = 1'b1;
  localparam logic WRN_IDLE = 1'b1;
endpackage

// File: rtl/coeff_addr_gen.sv
// Linear tap counter plus bank-local mod-DEPTH address; shared with the filter controller.
module coeff_addr_gen
  import fir_coeff_pkg::*;
#(
  parameter int DEPTH = BANK_DEPTH,
  parameter int TAPS  = MAX_TAPS,
  parameter int AW    = ADDR_W,
  parameter int TW    = TAP_W
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [TW-1:0] o_tap,
  output logic [AW-1:0] o_addr,
  output logic          o_wrap,
  output logic          o_last
);
  logic [TW-1:0] r_tap;
  logic [AW-1:0] r_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_tap  <= '0;
      r_addr <= '0;
    end else if (i_inc) begin
      r_tap  <= o_last ? '0 : r_tap + 1'b1;
      r_addr <= o_wrap ? '0 : r_addr + 1'b1;
    end
  end

  assign o_tap  = r_tap;
  assign o_addr = r_addr;
  assign o_wrap = (r_addr == AW'(DEPTH - 1));
  assign o_last = (r_tap == TW'(TAPS - 1));
endmodule

// File: rtl/coeff_load_sequencer.sv
// Streams N coefficients into the FIR coefficient RAM and zero-fills the remaining taps.
module coeff_load_sequencer
  import fir_coeff_pkg::*;
(
  input  logic                      iClk_12M,
  input  logic                      iRst,
  input  logic                      iLoadStart,
  input  logic [TAP_W-1:0]          iNumTaps,
  input  logic                      iCoeffValid,
  input  logic signed [COEFF_W-1:0] iCoeffData,
  output logic                      oCoeffReady,
  output logic                      oCoeffiUpdateFlag,
  output logic                      oCsnRam,
  output logic                      oWrnRam,
  output logic [ADDR_W-1:0]         oAddrRam,
  output logic signed [COEFF_W-1:0] oWrDtRam,
  output logic [TAP_W-1:0]          oNumOfCoeff,
  output logic                      oBusy,
  output logic                      oDone,
  output logic                      oErr
);
  state_t                r_state, w_nxt_state;
  logic [TAP_W-1:0]      r_n;
  logic                  r_flag, r_csn, r_wrn, r_done, r_err;
  logic [ADDR_W-1:0]     r_addr;
  logic [COEFF_W-1:0]    r_data;

  logic [TAP_W-1:0]      w_tap;
  logic [ADDR_W-1:0]     w_addr;
  logic                  w_wrap, w_last;
  logic                  w_ready, w_acc, w_wr, w_start, w_num_ok;
  logic [COEFF_W-1:0]    w_data;

  coeff_addr_gen u_addr_gen (
    .i_clk  (iClk_12M),
    .i_rst  (iRst),
    .i_clr  (r_state == IDLE),
    .i_inc  (w_wr),
    .o_tap  (w_tap),
    .o_addr (w_addr),
    .o_wrap (w_wrap),
    .o_last (w_last)
  );

  assign w_ready  = (r_state == STREAM) && (w_tap < r_n);
  assign w_acc    = w_ready && iCoeffValid;
  assign w_start  = (r_state == IDLE) && iLoadStart;
  assign w_num_ok = (iNumTaps != '0) && (iNumTaps <= TAP_W'(MAX_TAPS));

  always_comb begin
    w_nxt_state = r_state;
    w_wr        = 1'b0;
    w_data      = '0;
    case (r_state)
      IDLE:   if (w_start && w_num_ok) w_nxt_state = ARM;
      ARM:    w_nxt_state = STREAM;
      STREAM: begin
        w_wr   = w_acc;
        w_data = iCoeffData;
        if (w_acc && (w_tap == r_n - 1'b1))
          w_nxt_state = (r_n == TAP_W'(MAX_TAPS)) ? DONE : FILL;
      end
      FILL: begin
        // Zero slots use the same counter, so bank wrap stays in step with the filter
        w_wr = 1'b1;
        if (w_last) w_nxt_state = DONE;
      end
      DONE:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      r_state <= IDLE;
      r_n     <= '0;
      r_flag  <= 1'b0;
      r_csn   <= CSN_IDLE;
      r_wrn   <= WRN_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_flag  <= (w_nxt_state != IDLE);
      r_csn   <= w_wr ? ~CSN_IDLE : CSN_IDLE;
      r_wrn   <= w_wr ? ~WRN_IDLE : WRN_IDLE;
      if (w_wr) begin
        r_addr <= w_addr;
        r_data <= w_data;
      end
      r_done  <= (r_state == DONE);
      r_err   <= w_start && !w_num_ok;
      if (w_start && w_num_ok) r_n <= iNumTaps;
    end
  end

  assign oCoeffReady       = w_ready;
  assign oCoeffiUpdateFlag = r_flag;
  assign oCsnRam           = r_csn;
  assign oWrnRam           = r_wrn;
  assign oAddrRam          = r_addr;
  assign oWrDtRam          = r_data;
  assign oNumOfCoeff       = r_n;
  assign oBusy             = (r_state != IDLE);
  assign oDone             = r_done;
  assign oErr              = r_err;
endmodule
